alarm_tone_gen: RTL and testbench

- Upstream sample source for the audio output path.
- Produces a beeping square-wave alarm: a tone burst, then silence, repeated N times or until stopped.
- Drives left/right sample words and the write strobe into the audio controller's output FIFO, paced by the controller's audio_out_allowed.
- All timing is counted in written samples, so the pattern tracks the codec sample rate rather than CLOCK_50.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/square_osc.sv | 57 +++++
 rtl/alarm_tone_gen.sv | 123 ++++++++++++
 tb/tb_alarm_tone_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and defaults for the alarm tone generator
// Contents: alarm_state_t FSM encoding, 48 kHz default timing, default amplitude,
//           cnt_width() helper for sizing sample counters.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } alarm_state_t;

  // Defaults for a 48 kHz codec: 1 kHz tone, 250 ms on / 250 ms off, 3 beeps.
  localparam int          DEF_HALF_PERIOD = 24;
  localparam int          DEF_ON_SAMPLES  = 12000;
  localparam int          DEF_OFF_SAMPLES = 12000;
  localparam int          DEF_BEEPS       = 3;
  localparam logic [31:0] DEF_AMPLITUDE   = 32'd10000000;

  // Bits needed to count 0 .. max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/square_osc.sv
// rtl/square_osc.sv - square-wave phase counter, polarity and registered sample
// Ports: clk, rst_n     - clock, asynchronous active-low reset
//        clear          - restart on a positive half-cycle (tone entry)
//        advance        - one tone sample was written this cycle
//        mute           - next sample is silence
//        sample         - registered signed sample word
module square_osc
  import alarm_pkg::*;
#(
  parameter int          HALF_PERIOD = DEF_HALF_PERIOD,
  parameter logic [31:0] AMPLITUDE   = DEF_AMPLITUDE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic               mute,
  output logic signed [31:0] sample
);

  localparam int PW = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);
  localparam logic signed [31:0] POS = $signed(AMPLITUDE);
  localparam logic signed [31:0] NEG = -POS;

  logic [PW-1:0] phase_cnt;
  logic          negative;
  logic          neg_next;
  logic          wrap;

  assign wrap = (phase_cnt == PW'(HALF_PERIOD - 1));

  // Polarity the register will hold after this edge; the sample word is
  // loaded from it so the output matches the new phase immediately.
  always_comb begin
    neg_next = negative;
    if (clear)
      neg_next = 1'b0;
    else if (advance && wrap)
      neg_next = ~negative;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      negative  <= 1'b0;
      sample    <= '0;
    end else begin
      if (clear)
        phase_cnt <= '0;
      else if (advance)
        phase_cnt <= wrap ? '0 : phase_cnt + PW'(1);
      negative <= neg_next;
      sample   <= mute ? '0 : (neg_next ? NEG : POS);
    end
  end

endmodule

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - beeping square-wave alarm feeding the audio output FIFO
// Ports: CLOCK_50, resetn           - clock, asynchronous active-low reset
//        start, stop                - begin / abort the beep pattern
//        audio_out_allowed          - output FIFO has space
//        left/right_channel_audio_out - sample word (both channels identical)
//        write_audio_out            - FIFO write strobe
//        active, done               - pattern running / one-cycle completion pulse
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int          HALF_PERIOD = DEF_HALF_PERIOD,
  parameter logic [31:0] AMPLITUDE   = DEF_AMPLITUDE,
  parameter int          ON_SAMPLES  = DEF_ON_SAMPLES,
  parameter int          OFF_SAMPLES = DEF_OFF_SAMPLES,
  parameter int          BEEPS       = DEF_BEEPS
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic        audio_out_allowed,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        write_audio_out,
  output logic        active,
  output logic        done
);

  localparam int CNT_W  = cnt_width(ON_SAMPLES, OFF_SAMPLES);
  localparam int BEEP_W = (BEEPS < 2) ? 1 : $clog2(BEEPS + 1);

  alarm_state_t         state;
  logic [CNT_W-1:0]     sample_cnt;
  logic [BEEP_W-1:0]    beep_cnt;
  logic signed [31:0]   osc_sample;

  logic in_tone, in_gap;
  logic tone_end, gap_end, last_beep;
  logic osc_clear, osc_advance, osc_mute, stay_tone;

  assign in_tone = (state == TONE);
  assign in_gap  = (state == GAP);

  // Combinational so a full FIFO is never written.
  assign write_audio_out = audio_out_allowed && (in_tone || in_gap);
  assign active          = in_tone || in_gap;

  assign tone_end  = in_tone && write_audio_out && (sample_cnt == CNT_W'(ON_SAMPLES - 1));
  assign gap_end   = in_gap  && write_audio_out && (sample_cnt == CNT_W'(OFF_SAMPLES - 1));
  // beep_cnt has already counted the beep that just finished while in GAP.
  assign last_beep = (BEEPS != 0) && (beep_cnt == BEEP_W'(BEEPS));

  // Oscillator control mirrors the FSM's next state so the registered sample
  // is correct on the first cycle of every state.
  assign osc_clear   = !stop && (((state == IDLE) && start) || (gap_end && !last_beep));
  assign stay_tone   = !stop && in_tone && !tone_end;
  assign osc_advance = write_audio_out && in_tone;
  assign osc_mute    = !(osc_clear || stay_tone);

  square_osc #(
    .HALF_PERIOD (HALF_PERIOD),
    .AMPLITUDE   (AMPLITUDE)
  ) u_osc (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .clear   (osc_clear),
    .advance (osc_advance),
    .mute    (osc_mute),
    .sample  (osc_sample)
  );

  assign left_channel_audio_out  = osc_sample;
  assign right_channel_audio_out = osc_sample;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sample_cnt <= '0;
      beep_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        sample_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= TONE;
              sample_cnt <= '0;
              beep_cnt   <= '0;
            end
          end
          TONE: begin
            if (tone_end) begin
              state      <= GAP;
              sample_cnt <= '0;
              beep_cnt   <= beep_cnt + BEEP_W'(1);
            end else if (write_audio_out) begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (gap_end) begin
              sample_cnt <= '0;
              if (last_beep) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state <= TONE;
              end
            end else if (write_audio_out) begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// tb/tb_alarm_tone_gen.sv - self-checking bench for alarm_tone_gen
module tb_alarm_tone_gen;

  localparam logic [31:0] AMP = 32'd10000000;
  localparam logic [31:0] P   = AMP;
  localparam logic [31:0] N   = -AMP;

  logic        CLOCK_50 = 1'b0;
  logic        resetn, start, stop, allowed;
  logic [31:0] left_o, right_o;
  logic        wr, active, done;

  logic        c_start, c_stop, c_allowed;
  logic [31:0] c_left, c_right;
  logic        c_wr, c_active, c_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  alarm_tone_gen #(
    .HALF_PERIOD (2), .AMPLITUDE (AMP), .ON_SAMPLES (8), .OFF_SAMPLES (4), .BEEPS (2)
  ) dut (
    .CLOCK_50 (CLOCK_50), .resetn (resetn), .start (start), .stop (stop),
    .audio_out_allowed (allowed),
    .left_channel_audio_out (left_o), .right_channel_audio_out (right_o),
    .write_audio_out (wr), .active (active), .done (done)
  );

  alarm_tone_gen #(
    .HALF_PERIOD (2), .AMPLITUDE (AMP), .ON_SAMPLES (8), .OFF_SAMPLES (4), .BEEPS (0)
  ) dut_c (
    .CLOCK_50 (CLOCK_50), .resetn (resetn), .start (c_start), .stop (c_stop),
    .audio_out_allowed (c_allowed),
    .left_channel_audio_out (c_left), .right_channel_audio_out (c_right),
    .write_audio_out (c_wr), .active (c_active), .done (c_done)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic        allowed;
    logic        exp_wr;
    logic [31:0] exp_sample;
    logic        exp_active;
    logic        exp_done;
  } vec_t;

  vec_t        vec[26];
  logic [31:0] pat[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  initial begin
    int nw, viol, seen_done, mism, cdone;
    logic [31:0] got[$];
    logic pulsed;

    pat = '{P, P, N, N, P, P, N, N, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 24; i++)
      vec[i] = '{start: (i == 0), stop: 1'b0, allowed: 1'b1, exp_wr: 1'b1,
                 exp_sample: pat[i % 12], exp_active: 1'b1, exp_done: 1'b0};
    vec[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1};
    vec[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0};

    resetn = 1'b0; start = 1'b0; stop = 1'b0; allowed = 1'b1;
    c_start = 1'b0; c_stop = 1'b0; c_allowed = 1'b1;
    tick(); tick();
    chk("reset_sample", left_o, 32'd0);
    chk("reset_wr", {31'd0, wr}, 32'd0);
    chk("reset_active", {31'd0, active}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    resetn = 1'b1;
    tick();

    // Full pattern, cycle by cycle.
    for (int i = 0; i < 26; i++) begin
      start = vec[i].start; stop = vec[i].stop; allowed = vec[i].allowed;
      tick();
      start = 1'b0;
      chk($sformatf("full_wr[%0d]", i), {31'd0, wr}, {31'd0, vec[i].exp_wr});
      chk($sformatf("full_sample[%0d]", i), left_o, vec[i].exp_sample);
      chk($sformatf("full_right[%0d]", i), right_o, vec[i].exp_sample);
      chk($sformatf("full_active[%0d]", i), {31'd0, active}, {31'd0, vec[i].exp_active});
      chk($sformatf("full_done[%0d]", i), {31'd0, done}, {31'd0, vec[i].exp_done});
    end

    // Back-pressure: allowed toggles every cycle.
    allowed = 1'b1; start = 1'b1; tick(); start = 1'b0;
    viol = 0; seen_done = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (wr) got.push_back(left_o);
      if (wr && !allowed) viol++;
      if (done) begin seen_done = 1; break; end
      allowed = cyc[0];
      tick();
    end
    chk("bp_count", got.size(), 24);
    for (int i = 0; i < got.size() && i < 24; i++)
      chk($sformatf("bp_sample[%0d]", i), got[i], pat[i % 12]);
    chk("bp_no_write_blocked", viol, 0);
    chk("bp_done_seen", seen_done, 1);
    allowed = 1'b1;
    tick();

    // Start/stop collision from IDLE.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("coll_active", {31'd0, active}, 32'd0);
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr) nw++;
      tick();
    end
    chk("coll_writes", nw, 0);

    // Abort after the fifth write, then restart.
    start = 1'b1; tick(); start = 1'b0;
    nw = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr) nw++;
      if (nw == 5) break;
      tick();
    end
    chk("abort_reached5", nw, 5);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("abort_active", {31'd0, active}, 32'd0);
    chk("abort_wr", {31'd0, wr}, 32'd0);
    chk("abort_sample", left_o, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    tick();
    chk("abort_done_late", {31'd0, done}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("restart_sample[%0d]", i), left_o, pat[i]);
      chk($sformatf("restart_wr[%0d]", i), {31'd0, wr}, 32'd1);
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;

    // Asynchronous reset during GAP.
    start = 1'b1; tick(); start = 1'b0;
    nw = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr) nw++;
      if (nw == 10) break;
      tick();
    end
    chk("rst_in_gap_active", {31'd0, active}, 32'd1);
    chk("rst_in_gap_sample", left_o, 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_wr", {31'd0, wr}, 32'd0);
    chk("rst_async_active", {31'd0, active}, 32'd0);
    chk("rst_async_sample", left_o, 32'd0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr) nw++;
    end
    chk("rst_no_writes", nw, 0);

    // Continuous mode on the BEEPS=0 instance; a mid-run start is ignored.
    c_start = 1'b1; tick(); c_start = 1'b0;
    nw = 0; mism = 0; cdone = 0; pulsed = 1'b0;
    for (int i = 0; i < 400 && nw < 100; i++) begin
      if (c_done) cdone++;
      if (c_wr) begin
        if (c_left !== pat[nw % 12] || c_right !== c_left) begin
          mism++;
          if (mism <= 4)
            $display("FAIL cont_sample[%0d]: got %0h expected %0h", nw, c_left, pat[nw % 12]);
        end
        nw++;
      end
      c_start = (nw == 50) && !pulsed;
      if (c_start) pulsed = 1'b1;
      tick();
    end
    c_start = 1'b0;
    n_tests++;
    if (mism != 0) n_fail++;
    chk("cont_writes", nw, 100);
    chk("cont_done_never", cdone, 0);
    chk("cont_still_active", {31'd0, c_active}, 32'd1);
    c_stop = 1'b1; tick(); c_stop = 1'b0;
    chk("cont_stop", {31'd0, c_active}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
